// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch PC generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SRC_HOLD   = 2'd0,
        SRC_STEP   = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_TRAP   = 2'd3
    } pc_src_e;

    localparam int unsigned MASK_W = 64;

    // Mask that clears the low log2(step) bits; step must be a power of two.
    function automatic logic [MASK_W-1:0] align_mask(input int unsigned step);
        return ~(MASK_W'(step) - MASK_W'(1));
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC source selection and value computation (combinational).
// PC_GEN_MISALIGN_CHECK_EN: reject misaligned redirect targets instead of masking them.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  pc_state_e          i_state,
    input  logic               i_pc_valid,
    input  logic               i_pc_ready,
    input  logic [WIDTH-1:0]   i_pc,
    input  logic               i_trap_valid,
    input  logic [WIDTH-1:0]   i_trap_target,
    input  logic               i_branch_valid,
    input  logic [WIDTH-1:0]   i_branch_target,
    output pc_src_e            o_src_c,
    output logic [WIDTH-1:0]   o_pc_next_c,
    output logic               o_reject_c
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(align_mask(STEP));
    localparam logic [WIDTH-1:0] STEP_INC   = WIDTH'(STEP);

    logic [WIDTH-1:0] redir_target;

    // Fixed-priority source selection; HALT only honours traps.
    always_comb begin
        o_src_c = SRC_HOLD;
        unique case (i_state)
            RUN: begin
                if (i_trap_valid) begin
                    o_src_c = SRC_TRAP;
                end else if (i_branch_valid) begin
                    o_src_c = SRC_BRANCH;
                end else if (i_pc_valid && i_pc_ready) begin
                    o_src_c = SRC_STEP;
                end
            end
            HALT: begin
                if (i_trap_valid) begin
                    o_src_c = SRC_TRAP;
                end
            end
            default: ;
        endcase
    end

    // Next PC value; a rejected redirect leaves the PC where it is.
    always_comb begin
        redir_target = (o_src_c == SRC_TRAP) ? i_trap_target : i_branch_target;
        o_reject_c   = 1'b0;
        o_pc_next_c  = i_pc;
`ifdef PC_GEN_MISALIGN_CHECK_EN
        if (((o_src_c == SRC_TRAP) || (o_src_c == SRC_BRANCH))
            && (|(redir_target & ~ALIGN_MASK))) begin
            o_reject_c = 1'b1;
        end
`endif
        if (!o_reject_c) begin
            unique case (o_src_c)
                SRC_STEP:              o_pc_next_c = i_pc + STEP_INC;
                SRC_TRAP, SRC_BRANCH:  o_pc_next_c = redir_target & ALIGN_MASK;
                default:               o_pc_next_c = i_pc;
            endcase
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: holds the fetch PC, offers it via valid/ready,
// applies trap/branch redirects and debug halt/resume.
// PC_GEN_MISALIGN_CHECK_EN: misaligned redirects are rejected and flagged on
// o_misaligned; otherwise targets are aligned down and o_misaligned stays 0.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic [WIDTH-1:0]   o_pc,
    output logic               o_pc_valid,
    input  logic               i_pc_ready,
    input  logic               i_trap_valid,
    input  logic [WIDTH-1:0]   i_trap_target,
    input  logic               i_branch_valid,
    input  logic [WIDTH-1:0]   i_branch_target,
    input  logic               i_halt_req,
    input  logic               i_resume,
    output logic               o_halted,
    output logic               o_misaligned
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic             misaligned_q, misaligned_d;

    pc_src_e          src;
    logic [WIDTH-1:0] pc_next;
    logic             reject;
    logic             redirect;

    pc_next_sel #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next_sel (
        .i_state         (state_q),
        .i_pc_valid      (valid_q),
        .i_pc_ready      (i_pc_ready),
        .i_pc            (pc_q),
        .i_trap_valid    (i_trap_valid),
        .i_trap_target   (i_trap_target),
        .i_branch_valid  (i_branch_valid),
        .i_branch_target (i_branch_target),
        .o_src_c         (src),
        .o_pc_next_c     (pc_next),
        .o_reject_c      (reject)
    );

    // Next state and registered-output values.
    always_comb begin
        state_d      = state_q;
        redirect     = (src == SRC_TRAP) || (src == SRC_BRANCH);
        unique case (state_q)
            BOOT: state_d = i_halt_req ? HALT : RUN;
            RUN:  if (i_halt_req && !redirect) state_d = HALT;
            HALT: if (i_resume) state_d = RUN;
            default: state_d = BOOT;
        endcase
        pc_d         = pc_next;
        valid_d      = (state_d == RUN);
        halted_d     = (state_d == HALT);
        misaligned_d = reject;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VEC;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_pc_valid   = valid_q;
    assign o_halted     = halted_q;
    assign o_misaligned = misaligned_q;

endmodule
